// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer family.
package debounce_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  typedef struct packed {
    logic press_e;
    logic release_e;
    logic repeat_e;
  } deb_event_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running heartbeat: tick is high for one cycle every PERIOD cycles.
module tick_gen #(
  parameter int unsigned PERIOD = 2097152
) (
  input  logic sysclk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  // Tick is registered one count early so it lines up with count == PERIOD-1.
  always_comb begin
    count_d = count_q + CW'(1);
    if (count_q == CW'(PERIOD - 1)) count_d = '0;
    tick_d = (count_d == CW'(PERIOD - 1));
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/multi_debounce.sv
// N-channel push-button debouncer with press/release/auto-repeat pulses.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TICK_PERIOD  = 2097152,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned ONEHOT       = 1,
  parameter int unsigned REPEAT_DELAY = 0,
  parameter int unsigned REPEAT_RATE  = 1
) (
  input  logic                sysclk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] x,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_p,
  output logic [CHANNELS-1:0] release_p,
  output logic [CHANNELS-1:0] repeat_p
);

  localparam int unsigned SW   = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam int unsigned RMAX = REPEAT_DELAY + REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [CHANNELS-1:0] s1_q, xs_q;
  logic [CHANNELS-1:0] q;
  logic                tick;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      xs_q <= '0;
    end else begin
      s1_q <= x;
      xs_q <= s1_q;
    end
  end

  tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic          lvl_q, lvl_d;
    deb_event_t    ev_q, ev_d;

    // In exclusive mode a channel only counts as pressed when it is alone.
    if (ONEHOT != 0) begin : g_oh
      assign q[i] = xs_q[i] & ~|(xs_q & ~(CHANNELS'(1) << i));
    end else begin : g_ind
      assign q[i] = xs_q[i];
    end

    always_comb begin
      cnt_d    = cnt_q;
      rcnt_d   = rcnt_q;
      lvl_d    = lvl_q;
      ev_d     = '0;
      cnt_inc  = cnt_q + SW'(1);
      rcnt_inc = (rcnt_q == RW'(RMAX)) ? rcnt_q : rcnt_q + RW'(1);
      if (tick) begin
        if (q[i] == lvl_q) begin
          cnt_d = '0;
        end else if (cnt_inc == SW'(STABLE_TICKS)) begin
          cnt_d          = '0;
          lvl_d          = q[i];
          ev_d.press_e   = q[i];
          ev_d.release_e = ~q[i];
        end else begin
          cnt_d = cnt_inc;
        end
        // Repeat counter runs only across ticks where the level stays high.
        if (ev_d.press_e || !lvl_d) begin
          rcnt_d = '0;
        end else if (REPEAT_DELAY > 0) begin
          if (rcnt_inc == RW'(REPEAT_DELAY) || rcnt_inc == RW'(RMAX)) begin
            ev_d.repeat_e = 1'b1;
            rcnt_d        = RW'(REPEAT_DELAY);
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
      end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        rcnt_q <= '0;
        lvl_q  <= 1'b0;
        ev_q   <= '0;
      end else begin
        cnt_q  <= cnt_d;
        rcnt_q <= rcnt_d;
        lvl_q  <= lvl_d;
        ev_q   <= ev_d;
      end
    end

    assign level[i]     = lvl_q;
    assign press_p[i]   = ev_q.press_e;
    assign release_p[i] = ev_q.release_e;
    assign repeat_p[i]  = ev_q.repeat_e;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Checks two debouncer configurations against a tick-level behavioural model.
module tb_multi_debounce;

  localparam int unsigned CH = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned S  = 3;

  logic          sysclk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] x;
  logic [CH-1:0] lvl_w [2];
  logic [CH-1:0] prs_w [2];
  logic [CH-1:0] rel_w [2];
  logic [CH-1:0] rep_w [2];

  int tests = 0;
  int fails = 0;

  // Instance 0: exclusive, no repeat. Instance 1: independent, repeat 5/2.
  multi_debounce #(
    .CHANNELS(CH), .TICK_PERIOD(P), .STABLE_TICKS(S),
    .ONEHOT(1), .REPEAT_DELAY(0), .REPEAT_RATE(1)
  ) dut_a (
    .sysclk(sysclk), .reset_n(reset_n), .x(x),
    .level(lvl_w[0]), .press_p(prs_w[0]), .release_p(rel_w[0]), .repeat_p(rep_w[0])
  );

  multi_debounce #(
    .CHANNELS(CH), .TICK_PERIOD(P), .STABLE_TICKS(S),
    .ONEHOT(0), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut_b (
    .sysclk(sysclk), .reset_n(reset_n), .x(x),
    .level(lvl_w[1]), .press_p(prs_w[1]), .release_p(rel_w[1]), .repeat_p(rep_w[1])
  );

  always #5 sysclk = ~sysclk;

  // Reference model state.
  logic [CH-1:0] m_s1, m_s2;
  int            edge_cnt;
  bit            m_lvl  [2][CH];
  int            m_run  [2][CH];
  int            m_hold [2][CH];
  bit            m_prs  [2][CH];
  bit            m_rel  [2][CH];
  bit            m_rep  [2][CH];

  function automatic int rdelay(input int k);
    return (k == 1) ? 5 : 0;
  endfunction

  function automatic int rrate(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    edge_cnt = 0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++) begin
        m_lvl[k][c] = 0; m_run[k][c] = 0; m_hold[k][c] = 0;
        m_prs[k][c] = 0; m_rel[k][c] = 0; m_rep[k][c] = 0;
      end
  endtask

  task automatic model_edge();
    logic [CH-1:0] xs;
    bit            qv;
    xs = m_s2;
    m_s2 = m_s1;
    m_s1 = x;
    edge_cnt++;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++) begin
        m_prs[k][c] = 0; m_rel[k][c] = 0; m_rep[k][c] = 0;
        if (edge_cnt % P == 0) begin
          qv = xs[c] && (k == 1 || $countones(xs) == 1);
          if (qv == m_lvl[k][c]) m_run[k][c] = 0;
          else begin
            m_run[k][c]++;
            if (m_run[k][c] == S) begin
              m_lvl[k][c] = qv;
              m_run[k][c] = 0;
              if (qv) begin m_prs[k][c] = 1; m_hold[k][c] = 0; end
              else m_rel[k][c] = 1;
            end
          end
          if (!m_prs[k][c] && !m_rel[k][c] && m_lvl[k][c]) begin
            m_hold[k][c]++;
            if (rdelay(k) > 0 && m_hold[k][c] >= rdelay(k) &&
                (m_hold[k][c] - rdelay(k)) % rrate(k) == 0)
              m_rep[k][c] = 1;
          end
        end
      end
  endtask

  task automatic check();
    for (int k = 0; k < 2; k++) begin
      logic [CH-1:0] el, ep, er, et;
      for (int c = 0; c < CH; c++) begin
        el[c] = m_lvl[k][c]; ep[c] = m_prs[k][c];
        er[c] = m_rel[k][c]; et[c] = m_rep[k][c];
      end
      tests++;
      assert (lvl_w[k] === el) else begin
        fails++; $error("FAIL level dut%0d @%0t: got %b want %b", k, $time, lvl_w[k], el);
      end
      tests++;
      assert (prs_w[k] === ep) else begin
        fails++; $error("FAIL press dut%0d @%0t: got %b want %b", k, $time, prs_w[k], ep);
      end
      tests++;
      assert (rel_w[k] === er) else begin
        fails++; $error("FAIL release dut%0d @%0t: got %b want %b", k, $time, rel_w[k], er);
      end
      tests++;
      assert (rep_w[k] === et) else begin
        fails++; $error("FAIL repeat dut%0d @%0t: got %b want %b", k, $time, rep_w[k], et);
      end
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    if (reset_n) model_edge();
    #1;
    check();
  endtask

  task automatic run_count(input int n, input int k, input int c,
                           output int np, output int nr, output int nt);
    np = 0; nr = 0; nt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      np += int'(prs_w[k][c]);
      nr += int'(rel_w[k][c]);
      nt += int'(rep_w[k][c]);
    end
  endtask

  // sel: 0 press pulse, 1 release pulse, 2 level high.
  task automatic wait_for(input int k, input int c, input int sel, input int budget,
                          input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      case (sel)
        0:       found = prs_w[k][c];
        1:       found = rel_w[k][c];
        default: found = lvl_w[k][c];
      endcase
    end
    tests++;
    assert (found === 1'b1) else begin
      fails++; $error("FAIL %s: event not seen within %0d cycles (got 0 want 1)", tag, budget);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++; $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int np, nr, nt;
    int r;
    reset_n = 1'b1;
    x = 4'b0001;
    model_reset();
    #1 reset_n = 1'b0;
    #1 check();
    step();
    step();
    reset_n = 1'b1;

    // Held from reset release: one press on channel 0 within 16 cycles.
    run_count(16, 0, 0, np, nr, nt);
    expect_int("t1_press_count", np, 1);
    tests++;
    assert (lvl_w[0] === 4'b0001) else begin
      fails++; $error("FAIL t1_level: got %b want %b", lvl_w[0], 4'b0001);
    end

    // Short glitch on channel 2 never qualifies.
    x = 4'b0000;
    wait_for(0, 0, 1, 40, "t2_release0");
    run_count(8, 0, 2, np, nr, nt);
    x = 4'b0100;
    for (int i = 0; i < 6; i++) step();
    x = 4'b0000;
    run_count(40, 0, 2, np, nr, nt);
    expect_int("t2_glitch_press", np, 0);
    expect_int("t2_glitch_release", nr, 0);

    // Two buttons in exclusive mode: no press until one drops.
    x = 4'b0011;
    run_count(40, 0, 0, np, nr, nt);
    expect_int("t3_dual_press", np, 0);
    x = 4'b0001;
    wait_for(0, 0, 0, 24, "t3_press0");
    tests++;
    assert (prs_w[0] === 4'b0001) else begin
      fails++; $error("FAIL t3_press_vec: got %b want %b", prs_w[0], 4'b0001);
    end

    // Independent channels press and release together.
    x = 4'b0000;
    for (int i = 0; i < 40; i++) step();
    x = 4'b1010;
    wait_for(1, 1, 0, 24, "t4_press1");
    tests++;
    assert (prs_w[1] === 4'b1010) else begin
      fails++; $error("FAIL t4_press_vec: got %b want %b", prs_w[1], 4'b1010);
    end
    x = 4'b0000;
    wait_for(1, 1, 1, 24, "t4_release1");
    tests++;
    assert (rel_w[1] === 4'b1010) else begin
      fails++; $error("FAIL t4_release_vec: got %b want %b", rel_w[1], 4'b1010);
    end

    // Auto-repeat at held ticks 5, 7, 9, 11; nothing after release.
    for (int i = 0; i < 20; i++) step();
    x = 4'b0001;
    wait_for(1, 0, 0, 30, "t5_press");
    run_count(46, 1, 0, np, nr, nt);
    expect_int("t5_repeats", nt, 4);
    x = 4'b0000;
    wait_for(1, 0, 1, 30, "t5_release");
    run_count(30, 1, 0, np, nr, nt);
    expect_int("t5_post_repeat", nt, 0);
    expect_int("t5_post_release", nr, 0);

    // Reset while held: cleared at once, then re-qualified from zero.
    x = 4'b0001;
    wait_for(0, 0, 2, 40, "t6_level");
    do_reset();
    tests++;
    assert (lvl_w[0] === 4'b0000) else begin
      fails++; $error("FAIL t6_level_cleared: got %b want %b", lvl_w[0], 4'b0000);
    end
    run_count(20, 0, 0, np, nr, nt);
    expect_int("t6_repress", np, 1);

    // Random stimulus against the model.
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       x = 4'b0000;
        1:       x = CH'(1) << $urandom_range(0, CH - 1);
        2:       x = CH'($urandom_range(0, 15));
        default: x = x;
      endcase
      if ($urandom_range(0, 29) == 0) do_reset();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
